// File: rtl/bp_network_pkg.sv
// Shared types and helpers for the network packet scheduler.
// The flit layout macro lets each instance size the struct from its own parameters.
`define BP_NETWORK_FLIT_S(dest_w, data_w) struct packed { logic [(dest_w)-1:0] dest_id; logic [(data_w)-1:0] payload; }

package bp_network_pkg;

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_send = 1'b1
  } bp_sched_state_e;

  function automatic int num_flits(input int src_w, input int pkt_w);
    return (src_w + pkt_w - 1) / pkt_w;
  endfunction

  // Counter/pointer width, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_network_rr_arb.sv
// Combinational round-robin pick: first valid requester at or after ptr_i, wrapping.
module bp_network_rr_arb
  import bp_network_pkg::*;
#(
  parameter int num_req_p   = 2,
  parameter int ptr_width_p = 1
) (
  input  logic [num_req_p-1:0]   v_i,
  input  logic [ptr_width_p-1:0] ptr_i,
  output logic [num_req_p-1:0]   grant_o,
  output logic [ptr_width_p-1:0] grant_idx_o,
  output logic                   grant_v_o
);

  int best_dist_s;
  int best_idx_s;
  int dist_s;

  // Pick the valid requester with the smallest rotated distance from ptr_i
  always_comb begin
    best_dist_s = num_req_p;
    best_idx_s  = 0;
    dist_s      = 0;
    for (int j = 0; j < num_req_p; j++) begin
      dist_s = (j + num_req_p - int'(ptr_i)) % num_req_p;
      if (v_i[j] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        best_idx_s  = j;
      end else begin
      end
    end
    grant_v_o   = (best_dist_s < num_req_p);
    grant_idx_o = ptr_width_p'(best_idx_s);
    for (int j = 0; j < num_req_p; j++) begin
      grant_o[j] = grant_v_o && (best_idx_s == j);
    end
  end

endmodule

// File: rtl/bp_network_packet_scheduler.sv
// Round-robin scheduler that serialises one wide packet at a time into dest-tagged flits
// over a valid/ready link, re-arbitrating on the last handshake for zero-bubble streaming.
module bp_network_packet_scheduler
  import bp_network_pkg::*;
#(
  parameter int num_req_p           = 2,
  parameter int dest_id_width_p     = 4,
  parameter int source_data_width_p = 64,
  parameter int packet_data_width_p = 16
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic [num_req_p-1:0]                         v_i,
  input  logic [num_req_p*dest_id_width_p-1:0]         dest_id_i,
  input  logic [num_req_p*source_data_width_p-1:0]     data_i,
  output logic [num_req_p-1:0]                         yumi_o,
  output logic                                         v_o,
  output logic [dest_id_width_p+packet_data_width_p-1:0] data_o,
  output logic                                         last_o,
  input  logic                                         ready_i
);

  localparam int num_flits_lp    = num_flits(source_data_width_p, packet_data_width_p);
  localparam int cnt_width_lp    = cnt_width(num_flits_lp);
  localparam int ptr_width_lp    = cnt_width(num_req_p);
  localparam int padded_width_lp = num_flits_lp * packet_data_width_p;

  typedef `BP_NETWORK_FLIT_S(dest_id_width_p, packet_data_width_p) flit_t;

  bp_sched_state_e               state_r, state_n_s;
  logic [cnt_width_lp-1:0]       cnt_r, cnt_n_s;
  logic [ptr_width_lp-1:0]       ptr_r, ptr_n_s;
  logic [dest_id_width_p-1:0]    dest_r;
  logic [padded_width_lp-1:0]    payload_r;

  logic [num_req_p-1:0]          grant_oh_s;
  logic [ptr_width_lp-1:0]       grant_idx_s;
  logic [ptr_width_lp-1:0]       ptr_inc_s;
  logic                          grant_v_s;
  logic                          send_s;
  logic                          last_flit_s;
  logic                          arb_en_s;
  logic                          load_s;
  logic [source_data_width_p-1:0] win_data_s;
  logic [dest_id_width_p-1:0]    win_dest_s;
  logic [packet_data_width_p-1:0] slice_s;
  flit_t                         flit_s;

  bp_network_rr_arb #(
    .num_req_p   (num_req_p),
    .ptr_width_p (ptr_width_lp)
  ) rr_arb (
    .v_i         (v_i),
    .ptr_i       (ptr_r),
    .grant_o     (grant_oh_s),
    .grant_idx_o (grant_idx_s),
    .grant_v_o   (grant_v_s)
  );

  assign send_s      = (state_r == e_send);
  assign last_flit_s = send_s && (cnt_r == cnt_width_lp'(num_flits_lp - 1));
  // Arbitration is only open when idle or while the final flit is being accepted
  assign arb_en_s    = !reset_i && (!send_s || (last_flit_s && ready_i));
  assign yumi_o      = arb_en_s ? grant_oh_s : {num_req_p{1'b0}};
  assign ptr_inc_s   = (grant_idx_s == ptr_width_lp'(num_req_p - 1))
                       ? {ptr_width_lp{1'b0}} : grant_idx_s + ptr_width_lp'(1'b1);

  // One-hot AND-OR mux of the winning requester's packet and the current flit slice
  always_comb begin
    win_data_s = {source_data_width_p{1'b0}};
    win_dest_s = {dest_id_width_p{1'b0}};
    slice_s    = {packet_data_width_p{1'b0}};
    for (int i = 0; i < num_req_p; i++) begin
      win_data_s = win_data_s | ({source_data_width_p{grant_oh_s[i]}}
                                 & data_i[i*source_data_width_p +: source_data_width_p]);
      win_dest_s = win_dest_s | ({dest_id_width_p{grant_oh_s[i]}}
                                 & dest_id_i[i*dest_id_width_p +: dest_id_width_p]);
    end
    for (int k = 0; k < num_flits_lp; k++) begin
      slice_s = slice_s | ({packet_data_width_p{cnt_r == cnt_width_lp'(k)}}
                           & payload_r[k*packet_data_width_p +: packet_data_width_p]);
    end
  end

  // Next-state, flit counter and priority pointer
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    ptr_n_s   = ptr_r;
    load_s    = 1'b0;
    case (state_r)
      e_idle: begin
        if (arb_en_s && grant_v_s) begin
          load_s    = 1'b1;
          cnt_n_s   = {cnt_width_lp{1'b0}};
          ptr_n_s   = ptr_inc_s;
          state_n_s = e_send;
        end else begin
          state_n_s = e_idle;
        end
      end
      e_send: begin
        if (ready_i) begin
          if (last_flit_s) begin
            if (arb_en_s && grant_v_s) begin
              load_s    = 1'b1;
              cnt_n_s   = {cnt_width_lp{1'b0}};
              ptr_n_s   = ptr_inc_s;
              state_n_s = e_send;
            end else begin
              cnt_n_s   = {cnt_width_lp{1'b0}};
              state_n_s = e_idle;
            end
          end else begin
            cnt_n_s = cnt_r + cnt_width_lp'(1'b1);
          end
        end else begin
          state_n_s = e_send;
        end
      end
      default: begin
        state_n_s = e_idle;
      end
    endcase
  end

  // State and packet registers; payload is zero-extended so padding never holds stale bits
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_idle;
      cnt_r     <= {cnt_width_lp{1'b0}};
      ptr_r     <= {ptr_width_lp{1'b0}};
      dest_r    <= {dest_id_width_p{1'b0}};
      payload_r <= {padded_width_lp{1'b0}};
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      ptr_r   <= ptr_n_s;
      if (load_s) begin
        dest_r    <= win_dest_s;
        payload_r <= padded_width_lp'(win_data_s);
      end else begin
        dest_r    <= dest_r;
        payload_r <= payload_r;
      end
    end
  end

  assign flit_s.dest_id = dest_r;
  assign flit_s.payload = slice_s;
  assign v_o            = send_s;
  assign last_o         = last_flit_s;
  assign data_o         = send_s ? flit_s : {(dest_id_width_p + packet_data_width_p){1'b0}};

endmodule

// File: tb/tb_bp_network_packet_scheduler.sv
// Scoreboard bench: a behavioural arbiter/serialiser model pushes expected flits on each
// predicted grant; flits and grants are compared every cycle on the falling edge.
module tb_bp_network_packet_scheduler;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         ready_i = 1'b1;
  logic [1:0]   v_i = 2'b00;
  logic [7:0]   dest_id_i = 8'h00;
  logic [127:0] data_i = 128'h0;
  logic [1:0]   yumi_o;
  logic         v_o, last_o;
  logic [19:0]  data_o;

  logic [0:0]   pad_v = 1'b0;
  logic [3:0]   pad_dest = 4'h0;
  logic [39:0]  pad_data = 40'h0;
  logic         pad_ready = 1'b1;
  logic [0:0]   pad_yumi;
  logic         pad_v_o, pad_last;
  logic [19:0]  pad_data_o;

  bp_network_packet_scheduler dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .dest_id_i(dest_id_i), .data_i(data_i),
    .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o), .last_o(last_o), .ready_i(ready_i)
  );

  bp_network_packet_scheduler #(
    .num_req_p(1), .dest_id_width_p(4), .source_data_width_p(40), .packet_data_width_p(16)
  ) dut_pad (
    .clk_i(clk), .reset_i(reset_i), .v_i(pad_v), .dest_id_i(pad_dest), .data_i(pad_data),
    .yumi_o(pad_yumi), .v_o(pad_v_o), .data_o(pad_data_o), .last_o(pad_last), .ready_i(pad_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [67:0] req0_q[$];
  logic [67:0] req1_q[$];
  logic [20:0] exp_q[$];
  logic [20:0] pad_q[$];
  logic [1:0]  glog[$];
  int          cons_cnt0 = 0, cons_cnt1 = 0;
  int          pop_cnt0 = 0, pop_cnt1 = 0;
  int          hs_cnt = 0;
  logic        m_send = 1'b0;
  int          m_ptr = 0;

  // Reference model and checker for the main instance
  always @(negedge clk) begin
    int          w;
    int          idx;
    logic        hs;
    logic        last_hs;
    logic [1:0]  exp_yumi;
    logic [3:0]  pdest;
    logic [63:0] pdata;
    check_val("v_o", v_o, m_send);
    hs      = m_send && ready_i;
    last_hs = 1'b0;
    if (m_send) begin
      if (exp_q.size() == 0) begin
        check_val("sb_empty", 1, 0);
      end else begin
        check_val("data_o", data_o, exp_q[0][19:0]);
        check_val("last_o", last_o, exp_q[0][20]);
        last_hs = hs && exp_q[0][20];
      end
    end
    if (v_o && ready_i) hs_cnt++;
    if (yumi_o != 2'b00) glog.push_back(yumi_o);
    w = -1;
    if (!reset_i && (!m_send || last_hs)) begin
      for (int i = 0; i < 2; i++) begin
        idx = (m_ptr + i) % 2;
        if (w < 0 && v_i[idx]) w = idx;
      end
    end
    exp_yumi = 2'b00;
    if (w >= 0) exp_yumi[w] = 1'b1;
    check_val("yumi_o", yumi_o, exp_yumi);
    if (reset_i) begin
      exp_q.delete();
      m_send = 1'b0;
      m_ptr  = 0;
    end else begin
      if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
      if (w >= 0) begin
        pdest = dest_id_i[w*4 +: 4];
        pdata = data_i[w*64 +: 64];
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), pdest, pdata[k*16 +: 16]});
        m_send = 1'b1;
        m_ptr  = (w + 1) % 2;
        if (w == 0) cons_cnt0++; else cons_cnt1++;
      end else if (last_hs) begin
        m_send = 1'b0;
      end
    end
  end

  // Advance one cycle, retire consumed packets, present queue heads
  task automatic step();
    @(posedge clk);
    #1;
    while (pop_cnt0 < cons_cnt0) begin void'(req0_q.pop_front()); pop_cnt0++; end
    while (pop_cnt1 < cons_cnt1) begin void'(req1_q.pop_front()); pop_cnt1++; end
    v_i[0] = (req0_q.size() > 0);
    v_i[1] = (req1_q.size() > 0);
    {dest_id_i[3:0], data_i[63:0]}   = (req0_q.size() > 0) ? req0_q[0] : 68'h0;
    {dest_id_i[7:4], data_i[127:64]} = (req1_q.size() > 0) ? req1_q[0] : 68'h0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((req0_q.size() > 0 || req1_q.size() > 0 || m_send) && n < max_cycles) begin
      step();
      n++;
    end
    if (n >= max_cycles) check_val("drain_timeout", 1, 0);
  endtask

  initial begin
    int          c0;
    int          g0;
    logic [20:0] pexp;

    repeat (3) step();
    @(negedge clk);
    #1;
    check_val("rst_data_o", data_o, 0);
    check_val("rst_last_o", last_o, 0);
    check_val("rst_pad_v_o", pad_v_o, 0);
    step();
    reset_i = 1'b0;

    // single packet from req0
    req0_q.push_back({4'd3, 64'h1111_2222_3333_4444});
    drain(20);

    // backpressure in the middle of a packet
    req0_q.push_back({4'd9, 64'hdead_beef_cafe_f00d});
    step();
    step();
    ready_i = 1'b0;
    repeat (3) step();
    ready_i = 1'b1;
    drain(20);

    // fairness with both requesters continuously valid; ptr currently points at req1
    g0 = glog.size();
    req0_q.push_back({4'd1, 64'h0101_0202_0303_0404});
    req0_q.push_back({4'd2, 64'h0505_0606_0707_0808});
    req1_q.push_back({4'd5, 64'ha1a1_b2b2_c3c3_d4d4});
    req1_q.push_back({4'd6, 64'he5e5_f6f6_0707_1818});
    step();
    c0 = hs_cnt;
    repeat (8) step();
    @(negedge clk);
    #1;
    check_val("fair_flits", hs_cnt - c0, 8);
    drain(40);
    check_val("fair_ngrants", glog.size() - g0, 4);
    if (glog.size() - g0 >= 4) begin
      for (int i = 0; i < 4; i++) check_val("fair_order", glog[g0+i], (i % 2 == 0) ? 2'b10 : 2'b01);
    end

    // late arrival of req1 during req0's second flit
    g0 = glog.size();
    req0_q.push_back({4'd7, 64'h7777_6666_5555_4444});
    step();
    step();
    req1_q.push_back({4'd8, 64'h8888_9999_aaaa_bbbb});
    drain(30);
    check_val("late_ngrants", glog.size() - g0, 2);
    if (glog.size() - g0 >= 2) begin
      check_val("late_first", glog[g0], 2'b01);
      check_val("late_second", glog[g0+1], 2'b10);
    end

    // reset after two flits; ptr must return to req0
    req0_q.push_back({4'd4, 64'hc0de_c0de_1234_5678});
    step();
    step();
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    g0 = glog.size();
    req0_q.push_back({4'd4, 64'hc0de_c0de_1234_5678});
    req1_q.push_back({4'd2, 64'h0f0f_0f0f_f0f0_f0f0});
    drain(30);
    check_val("rst_ngrants", glog.size() - g0, 2);
    if (glog.size() - g0 >= 2) check_val("rst_first", glog[g0], 2'b01);

    // non-divisible width: 40-bit payload into three 16-bit flits
    step();
    pad_v    = 1'b1;
    pad_dest = 4'd5;
    pad_data = 40'hab_cdef_1234;
    pad_q.push_back({1'b0, 4'd5, 16'h1234});
    pad_q.push_back({1'b0, 4'd5, 16'hcdef});
    pad_q.push_back({1'b1, 4'd5, 16'h00ab});
    @(negedge clk);
    check_val("pad_yumi", pad_yumi, 1);
    @(posedge clk);
    #1;
    pad_v    = 1'b0;
    pad_dest = 4'h0;
    pad_data = 40'hff_ffff_ffff;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pexp = pad_q.pop_front();
      check_val("pad_v_o", pad_v_o, 1);
      check_val("pad_flit", {pad_last, pad_data_o}, pexp);
    end
    @(negedge clk);
    check_val("pad_v_done", pad_v_o, 0);

    drain(20);
    check_val("sb_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
